// File: rtl/agc_timing_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : agc_timing_pkg
// Description : Shared constants, timepulse state type and one-hot decode for
//               the AGC monitor timing front end.
// Revision    : 1.0 - initial release
// ============================================================================
package agc_timing_pkg;

    // Timepulses per memory cycle time (MT01..MT12)
    localparam int NUM_TP      = 12;
    // Flop depth used to bring asynchronous inputs onto SIM_CLK
    localparam int SYNC_STAGES = 2;

    // Timepulse state: 0 is idle (all MT low), 1..NUM_TP select MTn
    typedef logic [3:0] tp_state_t;

    localparam tp_state_t c_TP_IDLE  = 4'd0;
    localparam tp_state_t c_TP_FIRST = 4'd1;

    // Bit n-1 is set when the state equals n; idle decodes to all zero
    function automatic logic [NUM_TP-1:0] tp_onehot(input tp_state_t state);
        logic [NUM_TP-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_TP; i++) begin
            v[i] = (state == tp_state_t'(i + 1));
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/agc_sync_edge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : agc_sync_edge
// Description : Multi-flop synchronizer for one asynchronous input followed
//               by a registered rising-edge detector (one-cycle strobe).
// Revision    : 1.0 - initial release
// ============================================================================
module agc_sync_edge
    import agc_timing_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;

    // Shift the raw input through the synchronizer chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_sync = r_sync[STAGES-1];

    // Registered edge strobe: one cycle high after the synchronized 0->1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= o_sync;
            r_rise <= o_sync & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/agc_timepulse_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : agc_timepulse_monitor
// Description : Divides the sampled 2.048 MHz CLOCK into the one-hot monitor
//               timepulses MT01..MT12 and generates the monitor GOJAM that a
//               MSTRT edge releases at the start of the next MT01.
// Revision    : 1.0 - initial release
// ============================================================================
module agc_timepulse_monitor #(
    parameter int NUM_TP      = agc_timing_pkg::NUM_TP,
    parameter int SYNC_STAGES = agc_timing_pkg::SYNC_STAGES
) (
    input  logic SIM_CLK,
    input  logic SIM_RST,
    input  logic CLOCK,
    input  logic MSTRT,
    input  logic MSTP,
    input  logic STRT2,
    output logic MGOJAM,
    output logic MT01,
    output logic MT02,
    output logic MT03,
    output logic MT04,
    output logic MT05,
    output logic MT06,
    output logic MT07,
    output logic MT08,
    output logic MT09,
    output logic MT10,
    output logic MT11,
    output logic MT12
);
    import agc_timing_pkg::*;

    localparam tp_state_t c_TP_FINAL = tp_state_t'(NUM_TP);

    logic              w_clk_rise;
    logic              w_mstrt_rise;
    logic              w_mstp_sync;
    logic              w_strt2_sync;
    logic              w_clk_sync_unused;
    logic              w_mstrt_sync_unused;
    logic              w_mstp_rise_unused;
    logic              w_strt2_rise_unused;

    logic              r_presc;
    logic              w_tp_adv;
    tp_state_t         r_state;
    tp_state_t         w_state_next;
    logic [NUM_TP-1:0] r_mt;
    logic              r_gojam;
    logic              r_start_req;
    logic              w_release;

    agc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clock (
        .clk     (SIM_CLK),
        .rst     (SIM_RST),
        .i_async (CLOCK),
        .o_sync  (w_clk_sync_unused),
        .o_rise  (w_clk_rise)
    );

    agc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mstrt (
        .clk     (SIM_CLK),
        .rst     (SIM_RST),
        .i_async (MSTRT),
        .o_sync  (w_mstrt_sync_unused),
        .o_rise  (w_mstrt_rise)
    );

    agc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mstp (
        .clk     (SIM_CLK),
        .rst     (SIM_RST),
        .i_async (MSTP),
        .o_sync  (w_mstp_sync),
        .o_rise  (w_mstp_rise_unused)
    );

    agc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_strt2 (
        .clk     (SIM_CLK),
        .rst     (SIM_RST),
        .i_async (STRT2),
        .o_sync  (w_strt2_sync),
        .o_rise  (w_strt2_rise_unused)
    );

    // Advance on every second CLOCK rise, when the prescaler wraps 1->0
    assign w_tp_adv = w_clk_rise & r_presc;

    // Divide-by-two prescaler on the CLOCK rise strobe
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_presc <= 1'b0;
        end else if (w_clk_rise) begin
            r_presc <= ~r_presc;
        end
    end

    // Timepulse next state: idle and the last pulse both go to T01 unless MSTP holds
    always_comb begin
        w_state_next = r_state;
        if (w_tp_adv) begin
            if ((r_state == c_TP_IDLE) || (r_state == c_TP_FINAL)) begin
                w_state_next = w_mstp_sync ? c_TP_IDLE : c_TP_FIRST;
            end else begin
                w_state_next = r_state + 4'd1;
            end
        end
    end

    // State register and registered one-hot outputs updated on the same edge
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_state <= c_TP_IDLE;
            r_mt    <= '0;
        end else begin
            r_state <= w_state_next;
            r_mt    <= tp_onehot(w_state_next);
        end
    end

    // A pending start is honoured only at the advance that enters T01
    assign w_release = w_tp_adv && (w_state_next == c_TP_FIRST) && r_start_req;

    // GOJAM: STRT2 forces it and drops any request, otherwise a request releases it at T01
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_gojam     <= 1'b1;
            r_start_req <= 1'b0;
        end else if (w_strt2_sync) begin
            r_gojam     <= 1'b1;
            r_start_req <= 1'b0;
        end else if (w_release) begin
            r_gojam     <= 1'b0;
            r_start_req <= 1'b0;
        end else if (w_mstrt_rise) begin
            r_start_req <= 1'b1;
        end
    end

    assign MGOJAM = r_gojam;
    assign MT01   = r_mt[0];
    assign MT02   = r_mt[1];
    assign MT03   = r_mt[2];
    assign MT04   = r_mt[3];
    assign MT05   = r_mt[4];
    assign MT06   = r_mt[5];
    assign MT07   = r_mt[6];
    assign MT08   = r_mt[7];
    assign MT09   = r_mt[8];
    assign MT10   = r_mt[9];
    assign MT11   = r_mt[10];
    assign MT12   = r_mt[11];

endmodule
`default_nettype wire

// File: tb/tb_agc_timepulse_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_agc_timepulse_monitor
// Description : Randomized scoreboard bench for agc_timepulse_monitor. The
//               stimulus thread predicts each output change (vector and
//               SIM_CLK cycle) and queues it; a monitor compares changes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_agc_timepulse_monitor;

    // CLOCK rise driven at a negedge -> synchronizer, edge strobe, state register
    localparam int c_LAT_CLK = agc_timing_pkg::SYNC_STAGES + 2;
    // Level input (STRT2) driven at a negedge -> synchronizer, GOJAM register
    localparam int c_LAT_LVL = agc_timing_pkg::SYNC_STAGES + 1;

    logic SIM_CLK = 1'b0;
    logic SIM_RST = 1'b1;
    logic CLOCK   = 1'b0;
    logic MSTRT   = 1'b0;
    logic MSTP    = 1'b0;
    logic STRT2   = 1'b0;
    logic MGOJAM;
    logic MT01, MT02, MT03, MT04, MT05, MT06;
    logic MT07, MT08, MT09, MT10, MT11, MT12;

    agc_timepulse_monitor u_dut (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .CLOCK   (CLOCK),
        .MSTRT   (MSTRT),
        .MSTP    (MSTP),
        .STRT2   (STRT2),
        .MGOJAM  (MGOJAM),
        .MT01    (MT01),
        .MT02    (MT02),
        .MT03    (MT03),
        .MT04    (MT04),
        .MT05    (MT05),
        .MT06    (MT06),
        .MT07    (MT07),
        .MT08    (MT08),
        .MT09    (MT09),
        .MT10    (MT10),
        .MT11    (MT11),
        .MT12    (MT12)
    );

    always #10 SIM_CLK = ~SIM_CLK;

    int cyc = 0;
    always @(posedge SIM_CLK) cyc <= cyc + 1;

    typedef struct {
        logic [12:0] vec;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [12:0] prev_vec;

    // Reference model: timepulse number, CLOCK rises since reset, GOJAM, start request
    int          m_state = 0;
    int          m_rises = 0;
    bit          m_gojam = 1'b1;
    bit          m_req   = 1'b0;
    logic [12:0] m_vec   = 13'h1000;
    bit          rst7_done = 1'b0;

    function automatic logic [12:0] dut_vec();
        return {MGOJAM, MT12, MT11, MT10, MT09, MT08, MT07,
                MT06, MT05, MT04, MT03, MT02, MT01};
    endfunction

    function automatic logic [12:0] model_vec(input int st, input bit gj);
        logic [12:0] v;
        v = '0;
        v[12] = gj;
        if (st > 0) v[st-1] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Queue an expected output change if the model's visible outputs moved
    task automatic emit(input int when);
        logic [12:0] v;
        exp_t        e;
        v = model_vec(m_state, m_gojam);
        if (v != m_vec) begin
            e.vec = v;
            e.cyc = when;
            q.push_back(e);
            m_vec = v;
        end
    endtask

    task automatic drive_rise();
        @(negedge SIM_CLK);
        CLOCK = 1'b1;
        m_rises++;
        if (m_rises % 2 == 0) begin
            if (m_state == 0 || m_state == 12) m_state = MSTP ? 0 : 1;
            else                               m_state = m_state + 1;
            if (m_state == 1 && m_req && !STRT2) begin
                m_gojam = 1'b0;
                m_req   = 1'b0;
            end
            emit(cyc + c_LAT_CLK);
        end
    endtask

    task automatic drive_fall(input bit nm, input bit np, input bit ns);
        bit mstrt_edge;
        @(negedge SIM_CLK);
        CLOCK      = 1'b0;
        mstrt_edge = nm && !MSTRT;
        MSTRT      = nm;
        MSTP       = np;
        STRT2      = ns;
        if (STRT2) begin
            m_req   = 1'b0;
            m_gojam = 1'b1;
            emit(cyc + c_LAT_LVL);
        end else if (mstrt_edge) begin
            m_req = 1'b1;
        end
    endtask

    task automatic apply_reset();
        repeat (5) @(negedge SIM_CLK);
        @(posedge SIM_CLK);
        #5;
        SIM_RST = 1'b1;
        m_state = 0;
        m_rises = 0;
        m_gojam = 1'b1;
        m_req   = 1'b0;
        emit(cyc);
        #1;
        check("async_reset_outputs", dut_vec(), 13'h1000);
        repeat (10) @(posedge SIM_CLK);
        #5;
        SIM_RST = 1'b0;
        // A high MSTRT looks like a fresh edge once the synchronizer leaves reset
        if (MSTRT && !STRT2) m_req = 1'b1;
        repeat (4) @(negedge SIM_CLK);
    endtask

    // Monitor: every output change must match the head of the expectation queue
    always @(negedge SIM_CLK) begin
        if (mon_en) begin
            logic [12:0] cur;
            exp_t        e;
            cur = dut_vec();
            if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_change cycle=%0d actual=%h required=%h", e.cyc, cur, e.vec);
            end
            if (cur !== prev_vec) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cycle=%0d actual=%h required=%h", cyc, cur, prev_vec);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.vec || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL output_change actual=%h@%0d required=%h@%0d", cur, cyc, e.vec, e.cyc);
                    end
                end
                prev_vec = cur;
            end
        end
    end

    initial begin
        repeat (250) @(negedge SIM_CLK);
        check("reset_mgojam", {12'd0, MGOJAM}, 13'd1);
        check("reset_mt", {1'b0, dut_vec() & 13'h0fff}, 13'd0);
        prev_vec = dut_vec();
        mon_en   = 1'b1;
        @(posedge SIM_CLK);
        #5;
        SIM_RST = 1'b0;
        repeat (4) @(negedge SIM_CLK);

        for (int i = 0; i < 720; i++) begin
            int h;
            bit nm, np, ns, do_rst;
            h      = (i < 400) ? 12 : int'($urandom_range(6, 14));
            drive_rise();
            repeat (h - 1) @(negedge SIM_CLK);
            nm     = MSTRT;
            np     = MSTP;
            ns     = STRT2;
            do_rst = 1'b0;
            if (i < 400) begin
                case (i)
                    60:  nm = 1'b1;
                    70:  nm = 1'b0;
                    130: np = 1'b1;
                    170: np = 1'b0;
                    240: ns = 1'b1;
                    243: ns = 1'b0;
                    260: nm = 1'b1;
                    265: nm = 1'b0;
                    default: ;
                endcase
                if (i > 300 && !rst7_done && m_state == 7) begin
                    do_rst    = 1'b1;
                    rst7_done = 1'b1;
                end
            end else begin
                case ($urandom_range(0, 29))
                    0: nm = !nm;
                    1: np = !np;
                    2: ns = !ns;
                    3: do_rst = 1'b1;
                    default: ;
                endcase
            end
            drive_fall(nm, np, ns);
            if (do_rst) apply_reset();
            // Occasionally stop CLOCK (held low) to confirm nothing advances
            if (i >= 300 && $urandom_range(0, 39) == 0)
                repeat ($urandom_range(100, 300)) @(negedge SIM_CLK);
            repeat (h - 1) @(negedge SIM_CLK);
        end

        repeat (30) @(negedge SIM_CLK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
